sim_host_dev: RTL
=================

// Module: sim_host_dev
// PURPOSE
//   Memory-mapped simulation host device; the responder end of RVCPU's data-store bus.
//   RVCPU stores to it to report test completion (TOHOST) and to emit console bytes.
//   Completion drives done/pass/exit_code, which the bench uses to end simulation.
//   Console bytes are buffered in a FIFO drained by the bench.
//   Sits on the data bus behind the system address decoder; mem_req arrives already chip-selected.
// PARAMETERS
//   FIFO_DEPTH      16     console FIFO entries; power of two, >=2
//   TIMEOUT_CYCLES  100000 watchdog limit; used only with SIM_HOST_TIMEOUT_EN
// PORTS
//   clk            in   1   system clock; all logic on the rising edge
//   rst            in   1   synchronous, active-high reset
//   mem_req        in   1   access request; held stable until mem_ready
//   mem_we         in   1   1 = write, 0 = read
//   mem_addr       in   4   byte offset; word index is mem_addr[3:2]
//   mem_wdata      in   32  write data
//   mem_wstrb      in   4   byte enables; only wstrb[0] is checked, for CONSOLE
//   mem_ready      out  1   one-cycle completion pulse
//   mem_rdata      out  32  read data; valid while mem_ready=1, else 0
//   done           out  1   sticky test-finished flag
//   pass           out  1   valid when done=1
//   exit_code      out  31  failure code, valid when done=1
//   console_valid  out  1   FIFO head valid
//   console_data   out  8   FIFO head byte
//   console_ready  in   1   bench pops the head when valid&ready
// BEHAVIOUR
//   Register map (word index):
//     0 TOHOST  W/R
//     1 CONSOLE W; reads return 0
//     2 STATUS  R: {22'b0, full, empty, count[7:0]}
//     3 CYCLE   R: free-running 32-bit cycle count
//   Reset: every output is 0. FSM goes to IDLE; FIFO is emptied; CYCLE is cleared; TOHOST is cleared.
//     This applies mid-transaction too: the pending request is dropped with no mem_ready.
//   FSM states: IDLE, RESP, STALL.
//     IDLE: on mem_req, perform the access and go to RESP.
//       Exception: a CONSOLE write with a full FIFO goes to STALL instead.
//     RESP: mem_ready=1 for exactly one cycle, then IDLE.
//       A new request is not sampled in RESP, so back-to-back requests cost 2 cycles each.
//     STALL: hold until FIFO not full, then push the byte and go to RESP.
//       A pop in the same cycle as the stall check frees the space for that cycle.
//   Access latency: mem_ready rises the cycle after mem_req is first seen in IDLE (1 wait state).
//   TOHOST write: the value is stored.
//     bit0=1 and done=0: done<=1, pass<=(wdata==1), exit_code<=wdata[31:1].
//     bit0=0: value stored, flags unchanged.
//     Once done=1, TOHOST writes are still acknowledged, but done/pass/exit_code are frozen.
//   CONSOLE write: pushes wdata[7:0] only if wstrb[0]; otherwise it is acked and dropped.
//     Push and pop in the same cycle are both honoured; count is unchanged.
//   FIFO: count is 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
//     The pop happens at the clock edge where console_valid and console_ready are both 1.
//   CYCLE: increments every cycle after reset and wraps 0xFFFFFFFF->0.
//     It keeps counting after done.
//   mem_rdata is registered and captured at the transition into RESP.
// CONFIGURATION
//   SIM_HOST_TIMEOUT_EN defined:
//     If CYCLE reaches TIMEOUT_CYCLES with done=0, then next cycle done<=1, pass<=0, exit_code<=31'h7FFFFFFF.
//     If a TOHOST completion and the timeout land in the same cycle, TOHOST wins.
//   SIM_HOST_TIMEOUT_EN undefined: no watchdog; done is set only by TOHOST.
// TESTING
//   Write TOHOST=1 -> mem_ready 1 cycle after req; then done=1, pass=1, exit_code=0.
//   Write TOHOST=0x0000000B -> done=1, pass=0, exit_code=5.
//     A later write of 1 leaves pass=0 and exit_code=5.
//   Write 'H','i' to CONSOLE with console_ready=0 -> STATUS reads count=2.
//     Raise console_ready -> bytes 0x48 then 0x69, then empty=1.
//   Fill FIFO (16 writes), 17th write stalls with mem_ready low.
//     Pop one -> 17th acked in RESP; count stays 16.
//   Assert rst during STALL -> no mem_ready; count=0; done=0; CYCLE reads 1 on first read after release.
//   With SIM_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=50, no TOHOST write -> done=1, pass=0, exit_code=0x7FFFFFFF.

Source files
------------

// File: rtl/sim_host_dev.sv
// sim_host_dev: simulation host device on the data-store bus.
// Collects the TOHOST completion word (done/pass/exit_code) and buffers console
// bytes in a small FIFO that the bench drains through console_valid/ready.
// Optional watchdog: define SIM_HOST_TIMEOUT_EN to force a failing completion
// once CYCLE reaches TIMEOUT_CYCLES without a TOHOST completion.
module sim_host_dev #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        done,
  output logic        pass,
  output logic [30:0] exit_code,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

`ifdef SIM_HOST_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RESP, STALL} state_t;

  state_t state, state_nx;

  // register file / status
  logic [31:0] tohost;
  logic [31:0] cyc;
  logic [31:0] rdata_q;
  logic [31:0] rd_word;

  // console fifo
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic        full, empty, pop, push;

  // decode
  logic        is_con_push;
  logic        wr_tohost;
  logic        complete;
  logic        timeout;
  logic        cap;

  // address bits below the word index and upper strobes are not decoded
  logic        unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wstrb[3:1]};

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = console_valid & console_ready;

  assign console_valid = ~empty;
  assign console_data  = console_valid ? fifo_mem[rptr] : 8'h00;

  assign is_con_push = mem_req & mem_we & (mem_addr[3:2] == 2'd1) & mem_wstrb[0];
  assign wr_tohost   = (state == IDLE) & mem_req & mem_we & (mem_addr[3:2] == 2'd0);
  assign complete    = wr_tohost & mem_wdata[0] & ~done;
  assign timeout     = TMO_EN & ~done & (cyc == 32'(TIMEOUT_CYCLES));

  // mem_rdata only carries data during the acknowledge cycle
  assign mem_rdata = mem_ready ? rdata_q : 32'h0;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state: a pushing console write into a full fifo parks in STALL
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mem_req) state_nx = (is_con_push && full) ? STALL : RESP;
      RESP:    state_nx = IDLE;
      STALL:   if (!full || pop) state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  // outputs: ack in RESP, push decision, read-data capture strobe
  always_comb begin
    mem_ready = (state == RESP);
    push      = 1'b0;
    cap       = (state != RESP) && (state_nx == RESP);
    case (state)
      IDLE:    push = is_con_push & ~full;
      STALL:   push = ~full | pop;
      default: push = 1'b0;
    endcase
  end

  // read mux over the register map
  always_comb begin
    rd_word = 32'h0;
    case (mem_addr[3:2])
      2'd0:    rd_word = tohost;
      2'd2:    rd_word = {22'b0, full, empty, 8'(count)};
      2'd3:    rd_word = cyc;
      default: rd_word = 32'h0;
    endcase
  end

  // tohost, completion flags, cycle counter and captured read data
  always_ff @(posedge clk) begin
    if (rst) begin
      tohost    <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      exit_code <= '0;
      cyc       <= '0;
      rdata_q   <= '0;
    end else begin
      cyc <= cyc + 32'd1;
      if (wr_tohost) tohost <= mem_wdata;
      // a real completion takes precedence over the watchdog
      if (complete) begin
        done      <= 1'b1;
        pass      <= (mem_wdata == 32'd1);
        exit_code <= mem_wdata[31:1];
      end else if (timeout) begin
        done      <= 1'b1;
        pass      <= 1'b0;
        exit_code <= '1;
      end
      if (cap) rdata_q <= mem_we ? 32'h0 : rd_word;
    end
  end

  // fifo pointers and occupancy; simultaneous push/pop keeps count
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // fifo storage; when full, push and pop share a slot safely since the
  // head byte is consumed combinationally before the edge
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= mem_wdata[7:0];
  end

endmodule
